// File: rtl/sr_display_receiver.sv
// sr_display_receiver: receiving end of a 74HC595-style display shift-register link.
// The link pins are oversampled on clk. The design shifts on sr_clk rises, copies
// the shift register to storage on sr_latch rises, and gates the visible word with sr_oe_n.
// Optional frame-length checking is compiled in when SR_RX_FRAME_CHECK_EN is defined.
// Without it, o_frame_err and o_frame_err_seen are tied low.
module sr_display_receiver #(
  parameter int CHAIN_BITS  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_sr_data,
  input  logic                  i_sr_clk,
  input  logic                  i_sr_latch,
  input  logic                  i_sr_oe_n,
  output logic [CHAIN_BITS-1:0] o_display_word,
  output logic                  o_display_en,
  output logic                  o_frame_valid,
  output logic                  o_frame_err,
  output logic                  o_frame_err_seen
);

  // The level used as "synced" is taken one flop early, so edge detection
  // can use the final flop as the previous sample. This way a storage update
  // lands exactly SYNC_STAGES edges after the pin is first sampled high.
  localparam int DS = SYNC_STAGES - 1;

  logic [DS-1:0]          data_sync_q;
  logic [DS-1:0]          oe_n_sync_q;
  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] latch_sync_q;

  logic                  data_s;
  logic                  clk_rise_s;
  logic                  latch_rise_s;
  logic [CHAIN_BITS-1:0] shift_q, shift_d;
  logic [CHAIN_BITS-1:0] storage_q, storage_d;
  logic                  valid_q, valid_d;

  assign data_s       = data_sync_q[DS-1];
  assign clk_rise_s   = clk_sync_q[DS] == 1'b0 && clk_sync_q[DS-1] == 1'b1;
  assign latch_rise_s = latch_sync_q[DS] == 1'b0 && latch_sync_q[DS-1] == 1'b1;

  // Synchronizer chains for all four link inputs; the OE chain resets to "disabled".
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_sync_q  <= '0;
      oe_n_sync_q  <= '1;
      clk_sync_q   <= '0;
      latch_sync_q <= '0;
    end else begin
      data_sync_q[0]  <= i_sr_data;
      oe_n_sync_q[0]  <= i_sr_oe_n;
      clk_sync_q[0]   <= i_sr_clk;
      latch_sync_q[0] <= i_sr_latch;
      for (int k = 1; k < DS; k++) begin
        data_sync_q[k] <= data_sync_q[k-1];
        oe_n_sync_q[k] <= oe_n_sync_q[k-1];
      end
      for (int k = 1; k < SYNC_STAGES; k++) begin
        clk_sync_q[k]   <= clk_sync_q[k-1];
        latch_sync_q[k] <= latch_sync_q[k-1];
      end
    end
  end

  // Shift and storage next-state.
  // Storage copies the pre-shift value when both rises coincide.
  always_comb begin
    shift_d   = shift_q;
    storage_d = storage_q;
    valid_d   = 1'b0;
    if (clk_rise_s) begin
      shift_d = {shift_q[CHAIN_BITS-2:0], data_s};
    end else begin
      shift_d = shift_q;
    end
    if (latch_rise_s) begin
      storage_d = shift_q;
      valid_d   = 1'b1;
    end else begin
      storage_d = storage_q;
      valid_d   = 1'b0;
    end
  end

  // Shift register, storage register and frame-valid pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q   <= '0;
      storage_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      shift_q   <= shift_d;
      storage_q <= storage_d;
      valid_q   <= valid_d;
    end
  end

  assign o_display_en   = ~oe_n_sync_q[DS-1];
  assign o_display_word = o_display_en ? storage_q : '0;
  assign o_frame_valid  = valid_q;

`ifdef SR_RX_FRAME_CHECK_EN
  localparam int CNT_W   = $clog2(2 * CHAIN_BITS);
  localparam int CNT_MAX = 2 * CHAIN_BITS - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             seen_q, seen_d;

  // Count shifts since the last latch (saturating) and judge the frame length on latch.
  // A shift coinciding with the latch belongs to the next frame.
  always_comb begin
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    seen_d = seen_q;
    if (latch_rise_s) begin
      err_d  = (cnt_q != CNT_W'(CHAIN_BITS));
      seen_d = seen_q | err_d;
      cnt_d  = clk_rise_s ? CNT_W'(1) : CNT_W'(0);
    end else if (clk_rise_s && cnt_q != CNT_W'(CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Frame-length counter, error pulse and sticky error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      err_q  <= 1'b0;
      seen_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      err_q  <= err_d;
      seen_q <= seen_d;
    end
  end

  assign o_frame_err      = err_q;
  assign o_frame_err_seen = seen_q;
`else
  assign o_frame_err      = 1'b0;
  assign o_frame_err_seen = 1'b0;
`endif

endmodule

// File: tb/tb_sr_display_receiver.sv
// Scoreboard bench for sr_display_receiver.
// The reference model keeps the serial bit stream since reset; the expected storage
// is simply the last 32 bits sent before each latch.
module tb_sr_display_receiver;
  localparam int CB = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          sr_data, sr_clk, sr_latch, sr_oe_n;
  logic [CB-1:0] display_word;
  logic          display_en, frame_valid, frame_err, frame_err_seen;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] word;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  bit          hist[$];
  int          nbits    = 0;
  logic        exp_seen = 1'b0;
  logic [31:0] w;
  logic [63:0] v;
  logic        prev_valid = 1'b0;
  exp_t        mon_e;

  sr_display_receiver #(.CHAIN_BITS(CB), .SYNC_STAGES(2)) dut (
    .clk              (clk),
    .rst              (rst),
    .i_sr_data        (sr_data),
    .i_sr_clk         (sr_clk),
    .i_sr_latch       (sr_latch),
    .i_sr_oe_n        (sr_oe_n),
    .o_display_word   (display_word),
    .o_display_en     (display_en),
    .o_frame_valid    (frame_valid),
    .o_frame_err      (frame_err),
    .o_frame_err_seen (frame_err_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_word();
    logic [31:0] r = 32'h0;
    foreach (hist[i]) r = {r[30:0], hist[i]};
    return r;
  endfunction

  task automatic model_push(input bit b);
    hist.push_back(b);
    if (hist.size() > CB) void'(hist.pop_front());
    if (nbits < 2 * CB - 1) nbits++;
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic shift_bit(input bit b);
    sr_data = b;
    wait_clks(3);
    sr_clk = 1'b1;
    model_push(b);
    wait_clks(3);
    sr_clk = 1'b0;
  endtask

  task automatic send_bits(input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) shift_bit(val[i]);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", 32'(sb.size()), 32'h0);
      sb.delete();
    end
    #2;
    check("err_seen", {31'h0, frame_err_seen}, {31'h0, exp_seen});
  endtask

  task automatic do_latch(input bit with_bit, input bit b);
    exp_t e;
    e.word = model_word();
`ifdef SR_RX_FRAME_CHECK_EN
    e.err = (nbits != CB);
`else
    e.err = 1'b0;
`endif
    exp_seen = exp_seen | e.err;
    if (with_bit) begin
      sr_data = b;
      wait_clks(3);
      model_push(b);
      nbits = 1;
      sb.push_back(e);
      sr_clk   = 1'b1;
      sr_latch = 1'b1;
    end else begin
      nbits = 0;
      sb.push_back(e);
      sr_latch = 1'b1;
    end
    wait_clks(3);
    sr_clk   = 1'b0;
    sr_latch = 1'b0;
    wait_clks(3);
    wait_drain();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("rst_word",  display_word, 32'h0);
    check("rst_en",    {31'h0, display_en}, 32'h0);
    check("rst_valid", {31'h0, frame_valid}, 32'h0);
    check("rst_err",   {30'h0, frame_err, frame_err_seen}, 32'h0);
    sb.delete();
    hist.delete();
    nbits    = 0;
    exp_seen = 1'b0;
    wait_clks(2);
    rst = 1'b0;
    wait_clks(4);
  endtask

  // Monitor: pops the scoreboard on every valid pulse and checks pulse width.
  always @(negedge clk) begin
    if (frame_valid) begin
      check("valid_width", {31'h0, prev_valid}, 32'h0);
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'h1, 32'h0);
      end else begin
        mon_e = sb.pop_front();
        check("frame_word", display_word, mon_e.word);
        check("frame_err",  {31'h0, frame_err}, {31'h0, mon_e.err});
      end
    end
    prev_valid = frame_valid;
  end

  initial begin
    rst      = 1'b1;
    sr_data  = 1'b0;
    sr_clk   = 1'b0;
    sr_latch = 1'b0;
    sr_oe_n  = 1'b1;
    wait_clks(2);
    check("init_word", display_word, 32'h0);
    check("init_en",   {31'h0, display_en}, 32'h0);
    check("init_flags", {29'h0, frame_valid, frame_err, frame_err_seen}, 32'h0);
    rst = 1'b0;
    wait_clks(2);
    sr_oe_n = 1'b0;
    wait_clks(4);
    check("oe_enable", {31'h0, display_en}, 32'h1);

    // Basic 32-bit frame
    send_bits(64'hA5C30F81, 32);
    do_latch(1'b0, 1'b0);
    check("word_a5", display_word, 32'hA5C30F81);

    // Reset in the middle of a frame while a word is displayed
    send_bits(64'h15, 5);
    do_reset();
    send_bits(64'hA5C30F81, 32);
    do_latch(1'b0, 1'b0);

    // OE gating keeps storage
    sr_oe_n = 1'b1;
    wait_clks(4);
    check("oe_off_word", display_word, 32'h0);
    check("oe_off_en",   {31'h0, display_en}, 32'h0);
    sr_oe_n = 1'b0;
    wait_clks(4);
    check("oe_on_word", display_word, 32'hA5C30F81);
    check("oe_on_en",   {31'h0, display_en}, 32'h1);

    // Short and long frames
    send_bits(64'h7ACE1234, 31);
    do_latch(1'b0, 1'b0);
    send_bits(64'h1DEADBEEF, 33);
    do_latch(1'b0, 1'b0);
    // Latch with no preceding shifts reloads the same value
    do_latch(1'b0, 1'b0);

    // Simultaneous shift and latch
    send_bits(64'h12345678, 32);
    do_latch(1'b0, 1'b0);
    do_latch(1'b1, 1'b1);
    check("sim_pre", display_word, 32'h12345678);
    do_latch(1'b0, 1'b0);
    check("sim_post", display_word, 32'h2468ACF1);

    // Reset after a partial frame, then a full frame
    send_bits(64'hBEEF, 16);
    do_reset();
    send_bits(64'hFFFF0000, 32);
    do_latch(1'b0, 1'b0);
    check("after_rst", display_word, 32'hFFFF0000);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      int len;
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : CB;
      v = {$urandom(), $urandom()};
      send_bits(v, len);
      do_latch(($urandom_range(0, 3) == 0), v[0] ^ v[5]);
    end

    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
